// File: rtl/program_loader_if.sv
// Byte-stream handshake into the program loader: source drives valid/data,
// loader answers with ready; a byte moves on a clock edge with valid & ready.
interface program_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles a big-endian byte stream into 16-bit words, writes them
// to instruction memory from address 0 and releases the CPU once the XOR checksum matches.
module program_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   program_loader_if.slave       in_if,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [15:0]           imem_data,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR
   } state_t;

   state_t                state, state_nxt;
   logic [15:0]           count;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [7:0]            csum;
   logic [7:0]            hi_byte;
   logic                  accept;
   logic                  last_word;
   logic [15:0]           cnt_new;
   logic                  too_long;

   assign accept    = in_if.in_valid & in_if.in_ready;
   assign last_word = (32'(word_idx) == (32'(count) - 32'd1));
   assign cnt_new   = {count[15:8], in_if.in_data};
   // A full-capacity image (count == 2**ADDR_WIDTH) is legal; only beyond that overflows.
   assign too_long  = (32'(cnt_new) > (32'd1 << ADDR_WIDTH));

   always_ff @(posedge clock) begin
      if (reset) state <= CNT_HI;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CNT_HI: if (accept) state_nxt = CNT_LO;
         CNT_LO: if (accept) begin
            if (cnt_new == 16'd0) state_nxt = CHK;
            else if (too_long)    state_nxt = ERR;
            else                  state_nxt = DAT_HI;
         end
         DAT_HI: if (accept) state_nxt = DAT_LO;
         DAT_LO: if (accept) state_nxt = WRITE;
         WRITE:  state_nxt = last_word ? CHK : DAT_HI;
         CHK:    if (accept) state_nxt = (in_if.in_data == csum) ? DONE : ERR;
         DONE:   state_nxt = DONE;
         ERR:    state_nxt = ERR;
         default: state_nxt = CNT_HI;
      endcase
   end

   always_comb begin
      in_if.in_ready = 1'b0;
      imem_we        = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      case (state)
         CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK: in_if.in_ready = ~reset;
         WRITE:   imem_we = 1'b1;
         DONE:    done    = 1'b1;
         ERR:     error   = 1'b1;
         default: ;
      endcase
      cpu_reset = ~done;
   end

   // Address and data are captured with the lo byte so they are stable during WRITE.
   always_ff @(posedge clock) begin
      if (reset) begin
         count     <= 16'd0;
         word_idx  <= '0;
         csum      <= 8'd0;
         imem_addr <= '0;
         imem_data <= 16'd0;
      end else begin
         if (accept && (state != CHK)) csum <= csum ^ in_if.in_data;
         case (state)
            CNT_HI: if (accept) count[15:8] <= in_if.in_data;
            CNT_LO: if (accept) count[7:0]  <= in_if.in_data;
            DAT_HI: if (accept) hi_byte     <= in_if.in_data;
            DAT_LO: if (accept) begin
               imem_addr <= word_idx;
               imem_data <= {hi_byte, in_if.in_data};
            end
            WRITE:  if (!last_word) word_idx <= word_idx + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed plus randomized bench for program_loader; expected writes and final
// status come from a stream-level model of the boot image format.
module tb_program_loader;
   localparam int AW = 10;
   typedef logic [7:0] byte_q_t[$];

   logic            clock = 1'b0;
   logic            reset;
   logic            imem_we;
   logic [AW-1:0]   imem_addr;
   logic [15:0]     imem_data;
   logic            cpu_reset;
   logic            done;
   logic            error;

   program_loader_if bus ();

   program_loader #(.ADDR_WIDTH(AW)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_if     (bus.slave),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Observed transfers and writes, sampled mid-cycle
   int            acc_cyc[$];
   int            wr_cyc[$];
   logic [AW-1:0] wr_addr[$];
   logic [15:0]   wr_data[$];
   int            both_bad = 0;
   int            crst_bad = 0;

   always @(negedge clock) begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (imem_we) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_data);
      end
      if (done && error) both_bad++;
      if (cpu_reset !== ~done) crst_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      acc_cyc.delete();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      @(posedge clock); #1;
      chk({tag, " rst in_ready"}, 32'(bus.in_ready), 0);
      chk({tag, " rst imem_we"}, 32'(imem_we), 0);
      chk({tag, " rst imem_addr"}, 32'(imem_addr), 0);
      chk({tag, " rst imem_data"}, 32'(imem_data), 0);
      chk({tag, " rst cpu_reset"}, 32'(cpu_reset), 1);
      chk({tag, " rst done"}, 32'(done), 0);
      chk({tag, " rst error"}, 32'(error), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk({tag, " ready after rst"}, 32'(bus.in_ready), 1);
      clear_mon();
      both_bad = 0;
      crst_bad = 0;
   endtask

   // Present one byte and hold it until accepted; returns at posedge+1 of the transfer.
   task automatic send(input logic [7:0] b, input bit gaps, output bit ok);
      ok = 1'b0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clock);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (bus.in_ready) begin
            @(posedge clock); #1;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         @(posedge clock); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_stream(input string tag, input byte_q_t b, input bit gaps);
      bit ok;
      int n_ok = 0;
      foreach (b[i]) begin
         send(b[i], gaps, ok);
         if (!ok) break;
         n_ok++;
      end
      chk({tag, " bytes sent"}, 32'(n_ok), 32'(b.size()));
   endtask

   // Model: derive writes, consumed length and final status from the image format.
   task automatic check_result(input string tag, input byte_q_t b);
      int         cnt;
      int         nw;
      int         consumed;
      bit         ovf;
      bit         exp_done;
      logic [7:0] x;
      cnt = (int'(b[0]) << 8) | int'(b[1]);
      ovf = (cnt > (1 << AW));
      nw  = ovf ? 0 : cnt;
      x   = 8'h00;
      for (int i = 0; i < 2 + 2 * nw; i++) x ^= b[i];
      exp_done = !ovf && (b[2 + 2 * nw] == x);
      consumed = ovf ? 2 : 3 + 2 * nw;
      // Status must already be settled right after the final byte's edge.
      chk({tag, " done"}, 32'(done), 32'(exp_done));
      chk({tag, " error"}, 32'(error), 32'(!exp_done));
      chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
      chk({tag, " in_ready final"}, 32'(bus.in_ready), 0);
      repeat (3) @(posedge clock);
      #1;
      chk({tag, " accepted"}, 32'(acc_cyc.size()), 32'(consumed));
      chk({tag, " nwrites"}, 32'(wr_cyc.size()), 32'(nw));
      for (int k = 0; k < nw && k < wr_cyc.size(); k++) begin
         chk({tag, " addr"}, 32'(wr_addr[k]), 32'(k));
         chk({tag, " data"}, 32'(wr_data[k]), 32'({b[2 + 2 * k], b[3 + 2 * k]}));
         if (3 + 2 * k < acc_cyc.size())
            chk({tag, " latency"}, 32'(wr_cyc[k] - acc_cyc[3 + 2 * k]), 1);
      end
      chk({tag, " done&error"}, 32'(both_bad), 0);
      chk({tag, " cpu_reset=~done"}, 32'(crst_bad), 0);
   endtask

   function automatic byte_q_t make_image(input int cnt, input bit good_sum);
      byte_q_t    q;
      logic [7:0] x;
      q.push_back(8'(cnt >> 8));
      q.push_back(8'(cnt));
      for (int i = 0; i < 2 * cnt; i++) q.push_back(8'($urandom));
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      q.push_back(good_sum ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
      return q;
   endfunction

   initial begin
      byte_q_t t1, t2, t3, t4, img;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset        = 1'b1;

      // T1: two words, correct checksum
      do_reset("T1");
      t1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      run_stream("T1", t1, 1'b0);
      check_result("T1", t1);

      // T2: same image, bad checksum
      do_reset("T2");
      t2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      run_stream("T2", t2, 1'b0);
      check_result("T2", t2);

      // T3: empty image
      do_reset("T3");
      t3 = '{8'h00, 8'h00, 8'h00};
      run_stream("T3", t3, 1'b0);
      check_result("T3", t3);

      // T4: count 0x0401 overflows; further bytes refused
      do_reset("T4");
      t4 = '{8'h04, 8'h01};
      run_stream("T4", t4, 1'b0);
      check_result("T4", t4);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      repeat (5) begin
         @(negedge clock);
         chk("T4 refuse", 32'(bus.in_ready), 0);
      end
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      chk("T4 no extra accept", 32'(acc_cyc.size()), 2);

      // T5: full-capacity image with random gaps
      do_reset("T5");
      img = make_image(1 << AW, 1'b1);
      run_stream("T5", img, 1'b1);
      check_result("T5", img);

      // Random small images, good or bad checksum
      for (int r = 0; r < 4; r++) begin
         do_reset("RND");
         img = make_image($urandom_range(1, 9), 1'($urandom_range(0, 1)));
         run_stream("RND", img, 1'b1);
         check_result("RND", img);
      end

      // T6: reset one cycle after the first write, then a clean reload
      do_reset("T6");
      t4 = '{8'h00, 8'h02, 8'h12, 8'h34};
      run_stream("T6 part", t4, 1'b0);
      chk("T6 first we", 32'(imem_we), 1);
      chk("T6 first data", 32'(imem_data), 32'h1234);
      @(posedge clock); #1;
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAB;
      #1;
      chk("T6 ready in rst", 32'(bus.in_ready), 0);
      @(posedge clock); #1;
      chk("T6 rst addr", 32'(imem_addr), 0);
      chk("T6 rst data", 32'(imem_data), 0);
      chk("T6 rst we", 32'(imem_we), 0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      clear_mon();
      run_stream("T6", t1, 1'b0);
      check_result("T6", t1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
